// File: rtl/taxi_xgmii_rx_fault_32.sv
// taxi_xgmii_rx_fault_32
// 32-bit XGMII RX link fault monitor for the reconciliation sublayer.
// It detects local and remote fault sequence ordered sets and runs the
// clause 46 link fault state machine. It replaces every sequence ordered set
// with idle before the word reaches the MAC. It also drives fault status and
// the TX-side fault-response requests.
// Optional feature: define TAXI_XGMII_RX_FAULT_STATS_EN to add saturating
// counters of transitions into local and remote fault.
module taxi_xgmii_rx_fault_32 #(
   parameter int DATA_W     = 32,
   parameter int CTRL_W     = DATA_W/8,
   parameter int COL_THRESH = 128,
   parameter int SEQ_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_xgmii_rxd,
   input  logic [CTRL_W-1:0] s_xgmii_rxc,
   output logic [DATA_W-1:0] m_xgmii_rxd,
   output logic [CTRL_W-1:0] m_xgmii_rxc,
   output logic              stat_local_fault,
   output logic              stat_remote_fault,
   output logic              tx_req_remote_fault,
   output logic              tx_req_idle
`ifdef TAXI_XGMII_RX_FAULT_STATS_EN
   ,
   output logic [15:0]       stat_local_fault_cnt,
   output logic [15:0]       stat_remote_fault_cnt
`endif
);

   if (DATA_W != 32) begin : g_width_check
      $error("taxi_xgmii_rx_fault_32 supports only DATA_W == 32");
   end

   localparam logic [31:0] IDLE_D  = 32'h07070707;
   localparam logic [3:0]  IDLE_C  = 4'hF;
   localparam logic [7:0]  COL_MAX = 8'(COL_THRESH);
   localparam logic [2:0]  SEQ_MAX = 3'(SEQ_THRESH);

   // NONE doubles as the OK value of link_fault.
   typedef enum logic [1:0] {FLT_NONE, FLT_LOCAL, FLT_REMOTE} fault_t;
   typedef enum logic [1:0] {ST_INIT, ST_COUNT, ST_FAULT} state_t;

   state_t      state;
   fault_t      last_type;
   fault_t      link_fault;
   logic [7:0]  col_cnt;
   logic [2:0]  seq_cnt;

   logic        is_seq;
   fault_t      word_type;
   logic [7:0]  col_inc;
   logic [2:0]  seq_inc;
   logic        timeout;

   // Classify the incoming word and precompute counter increments.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      is_seq    = 1'b0;
      word_type = FLT_NONE;
      if (s_xgmii_rxc[3:0] == 4'b0001 && s_xgmii_rxd[7:0] == 8'h9C) begin
         is_seq = 1'b1;
         if (s_xgmii_rxd[31:8] == 24'h010000) begin
            word_type = FLT_LOCAL;
         end else if (s_xgmii_rxd[31:8] == 24'h020000) begin
            word_type = FLT_REMOTE;
         end
      end
      col_inc = (col_cnt >= COL_MAX) ? col_cnt : col_cnt + 8'd1;
      seq_inc = seq_cnt + 3'd1;
      // A fault word on the threshold cycle takes priority over the timeout.
      timeout = (word_type == FLT_NONE) && (col_inc >= COL_MAX);
   end

   // One-cycle datapath: sequence ordered sets become idle, all else passes through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_xgmii_rxd <= IDLE_D;
         m_xgmii_rxc <= IDLE_C;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         m_xgmii_rxd <= is_seq ? IDLE_D : s_xgmii_rxd;
         m_xgmii_rxc <= is_seq ? IDLE_C : s_xgmii_rxc;
      end
   end

   // Link fault state machine with column and sequence counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         last_type  <= FLT_NONE;
         link_fault <= FLT_NONE;
         col_cnt    <= 8'd0;
         seq_cnt    <= 3'd0;
`ifdef TAXI_XGMII_RX_FAULT_STATS_EN
         stat_local_fault_cnt  <= 16'd0;
         stat_remote_fault_cnt <= 16'd0;
`endif
      end else begin
         col_cnt <= (word_type != FLT_NONE) ? 8'd0 : col_inc;
         case (state)
            ST_INIT: begin
               if (word_type != FLT_NONE) begin
                  state     <= ST_COUNT;
                  seq_cnt   <= 3'd1;
                  last_type <= word_type;
               end
            end
            ST_COUNT: begin
               if (word_type != FLT_NONE) begin
                  if (word_type == last_type) begin
                     seq_cnt <= seq_inc;
                     if (seq_inc >= SEQ_MAX) begin
                        state      <= ST_FAULT;
                        link_fault <= word_type;
`ifdef TAXI_XGMII_RX_FAULT_STATS_EN
                        if (word_type != link_fault) begin
                           if (word_type == FLT_LOCAL && stat_local_fault_cnt != 16'hFFFF)
                              stat_local_fault_cnt <= stat_local_fault_cnt + 16'd1;
                           if (word_type == FLT_REMOTE && stat_remote_fault_cnt != 16'hFFFF)
                              stat_remote_fault_cnt <= stat_remote_fault_cnt + 16'd1;
                        end
`endif
                     end
                  end else begin
                     seq_cnt   <= 3'd1;
                     last_type <= word_type;
                  end
               end else if (timeout) begin
                  state      <= ST_INIT;
                  seq_cnt    <= 3'd0;
                  last_type  <= FLT_NONE;
                  link_fault <= FLT_NONE;
               end
            end
            ST_FAULT: begin
               if (word_type != FLT_NONE) begin
                  if (word_type != link_fault) begin
                     state     <= ST_COUNT;
                     seq_cnt   <= 3'd1;
                     last_type <= word_type;
                  end
               end else if (timeout) begin
                  state      <= ST_INIT;
                  seq_cnt    <= 3'd0;
                  last_type  <= FLT_NONE;
                  link_fault <= FLT_NONE;
               end
            end
            default: begin
               state      <= ST_INIT;
               seq_cnt    <= 3'd0;
               last_type  <= FLT_NONE;
               link_fault <= FLT_NONE;
            end
         endcase
      end
   end

   assign stat_local_fault    = (link_fault == FLT_LOCAL);
   assign stat_remote_fault   = (link_fault == FLT_REMOTE);
   assign tx_req_remote_fault = stat_local_fault;
   assign tx_req_idle         = stat_remote_fault;

endmodule
